// File: rtl/fetch_stage.sv
// fetch_stage: IF stage with PC, IF/ID register and event counters.
// Redirect beats stall beats advance; a synchronous reset beats all three.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   stall_i             hold PC and IF/ID for this cycle
//   branch_taken_i      redirect to branch_target_i and flush IF/ID
//   branch_target_i     redirect address (bits [1:0] dropped)
//   imem_addr_o         fetch address (the PC register)
//   imem_data_i         instruction at imem_addr_o, same cycle
//   ifid_pc4_o          PC+4 of the instruction in IF/ID
//   ifid_instr_o        instruction in IF/ID (0 when not valid)
//   ifid_valid_o        IF/ID holds a real instruction
//   stall_cnt_o         saturating count of stalled cycles
//   flush_cnt_o         saturating count of redirects
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             branch_taken_i,
  input  logic [31:0]      branch_target_i,
  output logic [31:0]      imem_addr_o,
  input  logic [31:0]      imem_data_i,
  output logic [31:0]      ifid_pc4_o,
  output logic [31:0]      ifid_instr_o,
  output logic             ifid_valid_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam logic [31:0] RST_PC = {RESET_PC[31:2], 2'b00};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pc4_q, pc4_d;
  logic [31:0]      instr_q, instr_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic        redir;
  logic        hold;
  logic [31:0] pc_plus4;

  // Make the two event selects mutually exclusive up front.
  assign redir    = branch_taken_i;
  assign hold     = stall_i & ~branch_taken_i;
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    pc_d        = pc_q;
    pc4_d       = pc4_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    unique case (1'b1)
      redir: begin
        pc_d    = {branch_target_i[31:2], 2'b00};
        pc4_d   = 32'd0;
        instr_d = 32'd0;
        valid_d = 1'b0;
        if (flush_cnt_q != CNT_MAX)
          flush_cnt_d = flush_cnt_q + CNT_ONE;
      end
      hold: begin
        if (stall_cnt_q != CNT_MAX)
          stall_cnt_d = stall_cnt_q + CNT_ONE;
      end
      default: begin
        pc_d    = {pc_plus4[31:2], 2'b00};
        pc4_d   = pc_plus4;
        instr_d = imem_data_i;
        valid_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q        <= RST_PC;
      pc4_q       <= 32'd0;
      instr_q     <= 32'd0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      pc4_q       <= pc4_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign imem_addr_o  = pc_q;
  assign ifid_pc4_o   = pc4_q;
  assign ifid_instr_o = instr_q;
  assign ifid_valid_o = valid_q;
  assign stall_cnt_o  = stall_cnt_q;
  assign flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: three instances (default, high RESET_PC,
// CNT_W=2) share stimulus and are checked against a reference model.
module tb_fetch_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] sc;
    logic [31:0] fc;
  } model_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [31:0] tgt = 32'd0;

  logic [31:0] addr [3];
  logic [31:0] data [3];
  logic [31:0] pc4  [3];
  logic [31:0] instr[3];
  logic        valid[3];
  logic [31:0] sc   [3];
  logic [31:0] fc   [3];

  logic [15:0] sc0, fc0, sc1, fc1;
  logic [1:0]  sc2, fc2;

  model_t m[3];
  bit     started = 1'b0;
  int     checks = 0;
  int     failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h2008_0001;
      32'h4:   return 32'h2009_0002;
      32'h8:   return 32'h200A_0003;
      default: return a ^ 32'h1357_9BDF;
    endcase
  endfunction

  function automatic logic [31:0] rpc(input int k);
    return (k == 1) ? 32'hFFFF_FFF8 : 32'h0;
  endfunction

  function automatic logic [31:0] cmax(input int k);
    return (k == 2) ? 32'd3 : 32'd65535;
  endfunction

  function automatic model_t step(input model_t s, input int k,
                                  input bit r, input bit st,
                                  input bit b, input logic [31:0] t);
    model_t n = s;
    if (r) begin
      n = '0;
      n.pc = rpc(k);
    end else if (b) begin
      n.pc    = t & 32'hFFFF_FFFC;
      n.pc4   = 0;
      n.instr = 0;
      n.valid = 0;
      n.fc    = (s.fc < cmax(k)) ? s.fc + 1 : s.fc;
    end else if (st) begin
      n.sc = (s.sc < cmax(k)) ? s.sc + 1 : s.sc;
    end else begin
      n.pc    = s.pc + 4;
      n.pc4   = s.pc + 4;
      n.instr = mem(s.pc);
      n.valid = 1;
    end
    return n;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_mem
    assign data[g] = mem(addr[g]);
  end

  fetch_stage u0 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall),
    .branch_taken_i(br), .branch_target_i(tgt),
    .imem_addr_o(addr[0]), .imem_data_i(data[0]),
    .ifid_pc4_o(pc4[0]), .ifid_instr_o(instr[0]),
    .ifid_valid_o(valid[0]),
    .stall_cnt_o(sc0), .flush_cnt_o(fc0)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) u1 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall),
    .branch_taken_i(br), .branch_target_i(tgt),
    .imem_addr_o(addr[1]), .imem_data_i(data[1]),
    .ifid_pc4_o(pc4[1]), .ifid_instr_o(instr[1]),
    .ifid_valid_o(valid[1]),
    .stall_cnt_o(sc1), .flush_cnt_o(fc1)
  );

  fetch_stage #(.CNT_W(2)) u2 (
    .clk_i(clk), .rst_i(rst), .stall_i(stall),
    .branch_taken_i(br), .branch_target_i(tgt),
    .imem_addr_o(addr[2]), .imem_data_i(data[2]),
    .ifid_pc4_o(pc4[2]), .ifid_instr_o(instr[2]),
    .ifid_valid_o(valid[2]),
    .stall_cnt_o(sc2), .flush_cnt_o(fc2)
  );

  assign sc[0] = 32'(sc0);
  assign fc[0] = 32'(fc0);
  assign sc[1] = 32'(sc1);
  assign fc[1] = 32'(fc1);
  assign sc[2] = 32'(sc2);
  assign fc[2] = 32'(fc2);

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++)
      m[k] <= step(m[k], k, rst, stall, br, tgt);
    if (rst) started <= 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("m%0d.addr", k), addr[k], m[k].pc);
        chk($sformatf("m%0d.pc4", k), pc4[k], m[k].pc4);
        chk($sformatf("m%0d.instr", k), instr[k], m[k].instr);
        chk($sformatf("m%0d.valid", k), 32'(valid[k]), 32'(m[k].valid));
        chk($sformatf("m%0d.scnt", k), sc[k], m[k].sc);
        chk($sformatf("m%0d.fcnt", k), fc[k], m[k].fc);
      end
    end
  end

  task automatic cyc(input bit r, input bit st, input bit b,
                     input logic [31:0] t);
    rst   = r;
    stall = st;
    br    = b;
    tgt   = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    cyc(1, 0, 0, 0);
    chk("rst.addr", addr[0], 32'h0);
    chk("rst.valid", 32'(valid[0]), 32'h0);
    chk("rst.instr", instr[0], 32'h0);
    chk("rst.hi_addr", addr[1], 32'hFFFF_FFF8);

    cyc(0, 0, 0, 0);
    chk("adv1.addr", addr[0], 32'h4);
    chk("adv1.pc4", pc4[0], 32'h4);
    chk("adv1.instr", instr[0], 32'h2008_0001);
    chk("adv1.valid", 32'(valid[0]), 32'h1);
    chk("wrap1", addr[1], 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0);
    chk("adv2.instr", instr[0], 32'h2009_0002);
    chk("wrap2", addr[1], 32'h0);
    cyc(0, 0, 0, 0);
    chk("adv3.addr", addr[0], 32'hC);
    chk("adv3.pc4", pc4[0], 32'hC);
    chk("adv3.instr", instr[0], 32'h200A_0003);
    chk("wrap3", addr[1], 32'h4);
    cyc(0, 0, 0, 0);
    chk("pc10", addr[0], 32'h10);

    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("stall.addr", addr[0], 32'h10);
    chk("stall.pc4", pc4[0], 32'h10);
    chk("stall.cnt", sc[0], 32'd2);
    cyc(0, 0, 0, 0);
    chk("unstall.pc4", pc4[0], 32'h14);
    chk("unstall.instr", instr[0], 32'h10 ^ 32'h1357_9BDF);

    cyc(0, 1, 1, 32'h43);
    chk("redir.addr", addr[0], 32'h40);
    chk("redir.instr", instr[0], 32'h0);
    chk("redir.valid", 32'(valid[0]), 32'h0);
    chk("redir.fcnt", fc[0], 32'd1);
    chk("redir.scnt", sc[0], 32'd2);

    cyc(0, 1, 0, 0);
    chk("bubble.valid", 32'(valid[0]), 32'h0);
    chk("bubble.addr", addr[0], 32'h40);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    cyc(0, 1, 0, 0);
    cyc(1, 1, 1, 32'h100);
    chk("rst2.addr", addr[0], 32'h0);
    chk("rst2.scnt", sc[0], 32'd0);
    chk("rst2.fcnt", fc[0], 32'd0);
    chk("rst2.valid", 32'(valid[0]), 32'h0);
    cyc(0, 0, 0, 0);
    chk("rst2.adv", addr[0], 32'h4);
    chk("rst2.pc4", pc4[0], 32'h4);

    cyc(0, 1, 0, 0);
    chk("sat1", sc[2], 32'd1);
    cyc(0, 1, 0, 0);
    chk("sat2", sc[2], 32'd2);
    cyc(0, 1, 0, 0);
    chk("sat3", sc[2], 32'd3);
    cyc(0, 1, 0, 0);
    chk("sat4", sc[2], 32'd3);
    cyc(0, 1, 0, 0);
    chk("sat5", sc[2], 32'd3);
    chk("nosat", sc[0], 32'd5);

    cyc(0, 0, 1, 32'hFFFF_FFFF);
    chk("tgt.mask", addr[0], 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0);
    chk("wrap.addr", addr[0], 32'h0);
    chk("wrap.pc4", pc4[0], 32'h0);

    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 32'h200 + 32'(i * 8));
    chk("fsat", fc[2], 32'd3);
    chk("fnosat", fc[0], 32'd6);

    for (int i = 0; i < 120; i++)
      cyc(0, (i % 5) == 2 || (i % 7) == 3, (i % 11) == 6,
          32'(i * 52 + 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset; bits [1:0] SHALL be 0.
REQ-002 Parameter CNT_W, default 16, width of the stall and flush event counters.
REQ-003 clk_i  input  1  single clock; all state SHALL update on the rising edge only.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 stall_i  input  1  load-use hazard stall from the downstream detection unit; 1 = hold PC and IF/ID.
REQ-006 branch_taken_i  input  1  redirect request from the ID/EX branch logic.
REQ-007 branch_target_i  input  32  redirect address; bits [1:0] ignored.
REQ-008 imem_addr_o  output  32  instruction memory address; combinational copy of the PC register.
REQ-009 imem_data_i  input  32  instruction word at imem_addr_o, valid in the same cycle (asynchronous-read memory).
REQ-010 ifid_pc4_o  output  32  registered PC+4 of the instruction held in IF/ID.
REQ-011 ifid_instr_o  output  32  registered instruction word held in IF/ID; 32'd0 (NOP) when not valid.
REQ-012 ifid_valid_o  output  1  1 = IF/ID holds a real fetched instruction.
REQ-013 stall_cnt_o  output  CNT_W  saturating count of stalled cycles.
REQ-014 flush_cnt_o  output  CNT_W  saturating count of redirects.

Function
REQ-015 State: PC register (32), IF/ID register {pc4, instr, valid}, two CNT_W counters.
REQ-016 imem_addr_o SHALL equal the PC register at all times, with no added latency.
REQ-017 Priority per cycle, outside reset: redirect > stall > normal advance.
REQ-018 Redirect (branch_taken_i=1): PC <= {branch_target_i[31:2],2'b00}; IF/ID <= {32'd0, 32'd0, 0}; flush_cnt_o += 1; stall_i is ignored in this cycle and stall_cnt_o is not incremented.
REQ-019 Stall (branch_taken_i=0, stall_i=1): PC, ifid_pc4_o, ifid_instr_o and ifid_valid_o hold their values; stall_cnt_o += 1.
REQ-020 Advance (both 0): PC <= PC+4; IF/ID <= {PC+4, imem_data_i, 1}.
REQ-021 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000), with no flag.
REQ-022 Counters SHALL saturate at all-ones and never wrap.
REQ-023 The PC register bits [1:0] SHALL always be 0.
REQ-024 Fetch-to-IF/ID latency SHALL be exactly 1 cycle; throughput SHALL be 1 instruction per cycle when there is no stall or redirect.
REQ-025 A stall lasting N consecutive cycles SHALL hold state for exactly N cycles. The instruction at the held PC is fetched again on the first non-stall cycle; no instruction is lost or duplicated in IF/ID.
REQ-026 A stall asserted while ifid_valid_o=0 SHALL hold the bubble (valid stays 0).

Reset
REQ-027 rst_i=1 at a clock edge: PC <= RESET_PC; ifid_pc4_o <= 0; ifid_instr_o <= 0; ifid_valid_o <= 0; both counters <= 0. rst_i SHALL override redirect and stall.
REQ-028 Reset asserted mid-stall or mid-redirect SHALL discard the pending operation. The first edge after rst_i falls SHALL perform a normal advance from RESET_PC.
REQ-029 There SHALL be no initial blocks for functional state; all values come from reset only.

Verification
REQ-030 Reset then 3 free cycles, imem returns 0x20080001/0x20090002/0x200A0003 -> imem_addr_o 0,4,8,12; IF/ID pc4 4,8,12; valid=1 from the first edge after reset.
REQ-031 With the PC at 0x10, stall_i=1 for 2 cycles -> imem_addr_o stays 0x10, IF/ID is unchanged, stall_cnt_o=2; the next cycle loads pc4=0x14.
REQ-032 branch_taken_i=1 with target 0x43 and stall_i=1 in the same cycle -> PC=0x40, ifid_instr_o=0, valid=0, flush_cnt_o=1, stall_cnt_o unchanged.
REQ-033 RESET_PC=32'hFFFF_FFF8, 3 free cycles -> PC sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
REQ-034 CNT_W=2, stall held for 5 cycles -> stall_cnt_o = 1,2,3,3,3.
REQ-035 rst_i asserted during a stall with counters nonzero -> all outputs at reset values on the next edge; the following edge advances to RESET_PC+4.
